// File: rtl/id_ex_hazard_pkg.sv
// Shared definitions for the decode/execute hazard scoreboard: register index
// width, default counter width and the debug encoding of the stall cause.
package id_ex_hazard_pkg;

   localparam int REG_IDX_W = 5;
   localparam int DEF_CNT_W = 2;

   typedef enum logic [1:0] {
      HZ_NONE     = 2'd0,
      HZ_RAW      = 2'd1,
      HZ_LOAD_USE = 2'd2,
      HZ_SAT      = 2'd3
   } hazard_cause_e;

endpackage

// File: rtl/id_ex_hazard_scoreboard_sb_reg_counter.sv
// One pending-write counter for a single architectural register. It can be
// bumped by an issue and lowered by writeback and by a flush in the same cycle;
// the result clamps at zero (flagging underflow) and at the maximum count.
module sb_reg_counter #(
   parameter int CNT_W = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic inc_i,
   input  logic dec_a_i,
   input  logic dec_b_i,
   output logic zero_o,
   output logic full_o,
   output logic underflow_o
);

   localparam logic [CNT_W+1:0] MAX_EXT = {2'b00, {CNT_W{1'b1}}};

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W+1:0] up_sum;
   logic [CNT_W+1:0] dn_sum;
   logic [CNT_W+1:0] net_sum;

   // Net update inc - dec_a - dec_b, clamped to [0, max]; going below zero pulses underflow.
   always_comb begin
      up_sum      = {2'b00, cnt_q} + {{(CNT_W+1){1'b0}}, inc_i};
      dn_sum      = {{(CNT_W+1){1'b0}}, dec_a_i} + {{(CNT_W+1){1'b0}}, dec_b_i};
      net_sum     = '0;
      cnt_d       = cnt_q;
      underflow_o = 1'b0;
      if (up_sum < dn_sum) begin
         cnt_d       = '0;
         underflow_o = 1'b1;
      end else begin
         net_sum = up_sum - dn_sum;
         if (net_sum > MAX_EXT) begin
            cnt_d = '1;
         end else begin
            cnt_d = net_sum[CNT_W-1:0];
         end
      end
   end

   // Count register, cleared asynchronously so a reset drops in-flight tracking at once.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);
   assign full_o = (cnt_q == '1);

endmodule

// File: rtl/id_ex_hazard_scoreboard.sv
// Scoreboard for the decode/execute boundary. It counts in-flight writes per
// register from issue to writeback, shadows the execute slot so a branch flush
// can retract the killed write, and decides whether decode must stall.
module id_ex_hazard_scoreboard
   import id_ex_hazard_pkg::*;
#(
   parameter int NUM_REGS   = 32,
   parameter int CNT_W      = DEF_CNT_W,
   parameter bit FORWARDING = 1'b1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 issue_valid_i,
   input  logic [REG_IDX_W-1:0] issue_rd_i,
   input  logic                 issue_reg_write_i,
   input  logic                 issue_mem_read_i,
   input  logic [REG_IDX_W-1:0] issue_rs1_i,
   input  logic [REG_IDX_W-1:0] issue_rs2_i,
   input  logic                 issue_use_rs1_i,
   input  logic                 issue_use_rs2_i,
   input  logic                 wb_valid_i,
   input  logic [REG_IDX_W-1:0] wb_rd_i,
   input  logic                 flush_i,
   output logic                 stall_o,
   output logic                 issue_accept_o,
   output logic [NUM_REGS-1:0]  pending_o,
   output logic                 busy_o,
   output logic                 err_underflow_o
);

   logic [NUM_REGS-1:0]  zero_w;
   logic [NUM_REGS-1:0]  full_w;
   logic [NUM_REGS-1:0]  uflow_w;

   logic                 ex_vld_q, ex_vld_d;
   logic                 ex_ld_q, ex_ld_d;
   logic [REG_IDX_W-1:0] ex_rd_q, ex_rd_d;
   logic                 err_underflow_q, err_underflow_d;

   logic                 src1_haz;
   logic                 src2_haz;
   logic                 sat_haz;
   hazard_cause_e        cause;
   logic                 accept_write;

   // x0 is hard-wired: never pending, never full, never underflows.
   assign zero_w[0]  = 1'b1;
   assign full_w[0]  = 1'b0;
   assign uflow_w[0] = 1'b0;

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
      sb_reg_counter #(
         .CNT_W(CNT_W)
      ) u_cnt (
         .clk_i      (clk_i),
         .rst_ni     (rst_ni),
         .inc_i      (accept_write && (issue_rd_i == REG_IDX_W'(r))),
         .dec_a_i    (wb_valid_i && (wb_rd_i == REG_IDX_W'(r))),
         .dec_b_i    (flush_i && ex_vld_q && (ex_rd_q == REG_IDX_W'(r))),
         .zero_o     (zero_w[r]),
         .full_o     (full_w[r]),
         .underflow_o(uflow_w[r])
      );
   end

   // Classify the decode instruction's hazard; source hazards take priority over saturation.
   always_comb begin
      src1_haz = 1'b0;
      src2_haz = 1'b0;
      sat_haz  = 1'b0;
      cause    = HZ_NONE;
      if (FORWARDING) begin
         src1_haz = issue_use_rs1_i && (issue_rs1_i != '0) && ex_vld_q && ex_ld_q
                    && (ex_rd_q == issue_rs1_i);
         src2_haz = issue_use_rs2_i && (issue_rs2_i != '0) && ex_vld_q && ex_ld_q
                    && (ex_rd_q == issue_rs2_i);
      end else begin
         src1_haz = issue_use_rs1_i && (issue_rs1_i != '0) && !zero_w[issue_rs1_i];
         src2_haz = issue_use_rs2_i && (issue_rs2_i != '0) && !zero_w[issue_rs2_i];
      end
      sat_haz = issue_reg_write_i && (issue_rd_i != '0) && full_w[issue_rd_i];
      if (src1_haz || src2_haz) begin
         cause = FORWARDING ? HZ_LOAD_USE : HZ_RAW;
      end else if (sat_haz) begin
         cause = HZ_SAT;
      end
   end

   assign stall_o        = issue_valid_i && (cause != HZ_NONE);
   assign issue_accept_o = issue_valid_i && !stall_o && !flush_i;
   assign accept_write   = issue_accept_o && issue_reg_write_i && (issue_rd_i != '0);

   // Next execute-slot shadow and sticky underflow flag.
   always_comb begin
      ex_vld_d        = accept_write;
      ex_rd_d         = ex_rd_q;
      ex_ld_d         = ex_ld_q;
      err_underflow_d = err_underflow_q || (|uflow_w);
      if (accept_write) begin
         ex_rd_d = issue_rd_i;
         ex_ld_d = issue_mem_read_i;
      end
   end

   // Execute-slot shadow and error flag registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ex_vld_q        <= 1'b0;
         ex_ld_q         <= 1'b0;
         ex_rd_q         <= '0;
         err_underflow_q <= 1'b0;
      end else begin
         ex_vld_q        <= ex_vld_d;
         ex_ld_q         <= ex_ld_d;
         ex_rd_q         <= ex_rd_d;
         err_underflow_q <= err_underflow_d;
      end
   end

   assign pending_o       = ~zero_w;
   assign busy_o          = |pending_o;
   assign err_underflow_o = err_underflow_q;

endmodule
